// File: rtl/msix_vec_sched.sv
// msix_vec_sched: MSI-X pending/mask/round-robin scheduler issuing one DW write per interrupt
//   clk, rst_n            : clock, synchronous active-low reset
//   intr_req, vec_mask    : per-vector request pulses and masks (1 = masked)
//   cfg_we/idx/addr/data  : vector-table write port
//   wr_valid/ready/addr/data/id : DW write handshake toward the host path
//   pend, coal_cnt, busy  : pending-bit array, saturating coalesce count, ISSUE indicator
module msix_vec_sched #(
   parameter int NUM_VEC = 8,
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 32,
   parameter int IDX_W   = $clog2(NUM_VEC)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_VEC-1:0] intr_req,
   input  logic [NUM_VEC-1:0] vec_mask,
   input  logic               cfg_we,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [ADDR_W-1:0]  cfg_addr,
   input  logic [DATA_W-1:0]  cfg_data,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [DATA_W-1:0]  wr_data,
   output logic [IDX_W-1:0]   wr_id,
   output logic [NUM_VEC-1:0] pend,
   output logic [15:0]        coal_cnt,
   output logic               busy
);
   localparam int HW = $clog2(NUM_VEC + 1);
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0]  addr_q [NUM_VEC];
   logic [DATA_W-1:0]  data_q [NUM_VEC];
   logic [NUM_VEC-1:0] pend_q, pend_d, elig, clr, coal_hit;
   logic [15:0]        coal_q, coal_d;
   logic [16:0]        coal_sum;
   logic [HW-1:0]      hits;
   logic [IDX_W-1:0]   last_q, win_idx, cand, wr_id_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic [DATA_W-1:0]  wr_data_q;
   logic               win_found, accept;
   // unprogrammed (addr == 0) and masked vectors stay pending but never compete
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_VEC; i++) elig[i] = pend_q[i] & ~vec_mask[i] & (addr_q[i] != '0);
   end
   // round-robin: first eligible vector after the last granted one
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_VEC; k++) begin
         cand = IDX_W'((int'(last_q) + k) % NUM_VEC);
         if (!win_found && elig[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end
   assign accept   = (state_q == ISSUE) & wr_ready;
   assign clr      = accept ? NUM_VEC'(1) << wr_id_q : '0;
   // a request landing on the accept cycle survives the clear as a fresh request
   assign pend_d   = (pend_q & ~clr) | intr_req;
   assign coal_hit = intr_req & pend_q & ~clr;
   always_comb begin
      hits = '0;
      for (int i = 0; i < NUM_VEC; i++) hits = hits + HW'(coal_hit[i]);
   end
   assign coal_sum = {1'b0, coal_q} + 17'(hits);
   assign coal_d   = coal_sum[16] ? 16'hFFFF : coal_sum[15:0];
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == IDLE) ? (win_found ? ISSUE : IDLE) : (wr_ready ? IDLE : ISSUE);
   end
   always_comb begin
      wr_valid = (state_q == ISSUE);
      busy     = (state_q == ISSUE);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q    <= '0;
         coal_q    <= '0;
         last_q    <= IDX_W'(NUM_VEC - 1);
         wr_id_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int i = 0; i < NUM_VEC; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         pend_q <= pend_d;
         coal_q <= coal_d;
         if (cfg_we) begin
            addr_q[cfg_idx] <= cfg_addr;
            data_q[cfg_idx] <= cfg_data;
         end
         // the write is snapshotted here so table/mask changes cannot disturb it in flight
         if (state_q == IDLE && win_found) begin
            wr_id_q   <= win_idx;
            wr_addr_q <= addr_q[win_idx];
            wr_data_q <= data_q[win_idx];
         end
         if (accept) last_q <= wr_id_q;
      end
   end
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign wr_id    = wr_id_q;
   assign pend     = pend_q;
   assign coal_cnt = coal_q;
endmodule

// File: doc/msix_vec_sched.md
# msix_vec_sched

MSI-X interrupt scheduler sitting between device-side interrupt sources and the host write path that posts DW writes into host memory. It latches per-vector interrupt requests into a pending array, honours per-vector masks, arbitrates round-robin among eligible vectors, and issues one address/data DW write per interrupt from a programmable vector table. It is the RTL counterpart to the host model's MSI-X vector list: each write it emits lands on a registered MSI-X address with the programmed data.

## Interface
Parameters:
- NUM_VEC, 8, number of MSI-X vectors (2..32)
- ADDR_W, 64, host address width
- DATA_W, 32, MSI-X message data width (one DW)
- IDX_W, $clog2(NUM_VEC), vector index width

Ports:
- clk  input  1  block clock
- rst_n  input  1  reset; **one clock; reset is synchronous and active-low**
- intr_req  input  NUM_VEC  per-vector request pulses (any number of bits per cycle)
- vec_mask  input  NUM_VEC  per-vector mask; 1 = masked
- cfg_we  input  1  vector-table write strobe
- cfg_idx  input  IDX_W  table entry to write
- cfg_addr  input  ADDR_W  message address for the entry
- cfg_data  input  DATA_W  message data for the entry
- wr_valid  output  1  DW write request to host path
- wr_ready  input  1  host path accepts write
- wr_addr  output  ADDR_W  write address
- wr_data  output  DATA_W  write data
- wr_id  output  IDX_W  vector index of the current write
- pend  output  NUM_VEC  pending-bit array (PBA)
- coal_cnt  output  16  saturating count of coalesced requests
- busy  output  1  high while in ISSUE

## Operation
- Vector table: NUM_VEC entries {addr, data}, reset to 0. cfg_we writes entry cfg_idx next edge. An entry with addr == 0 is unprogrammed.
- Pending: intr_req[i] sets pend[i]. If pend[i] already set and not being cleared that cycle, the request coalesces: coal_cnt += 1 per such bit, saturating at 0xFFFF.
- Eligible[i] = pend[i] & !vec_mask[i] & (table[i].addr != 0). Masked or unprogrammed vectors stay pending indefinitely and are never dropped.
- Arbitration: round-robin, search starts at last_grant+1 modulo NUM_VEC; last_grant resets to NUM_VEC-1, so vector 0 wins first.
- FSM:
  - IDLE: if any eligible, latch winner index, table addr and data into output regs; go ISSUE. Otherwise stay.
  - ISSUE: wr_valid=1, outputs held stable. On wr_ready: clear pend[wr_id], update last_grant=wr_id, go IDLE.
- Latched values are used for the whole ISSUE; a cfg_we to that entry or a mask change during ISSUE does not alter or abort the in-flight write.
- An intr_req on wr_id in the same cycle as its acceptance leaves pend set (fresh request, not coalesced).
- Reset mid-ISSUE: write abandoned, wr_valid drops on the reset edge, all pending state lost.

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, wr_id=0, pend=0, coal_cnt=0, busy=0, table all 0.
- intr_req at cycle N -> pend at N+1 -> wr_valid at N+2 if idle, unmasked and programmed.
- wr_valid, once raised, stays high with stable addr, data and id until the wr_ready cycle; acceptance occurs when wr_valid & wr_ready. wr_valid falls the next cycle.
- Throughput: one write per 2 cycles maximum (ISSUE always followed by at least one IDLE cycle).
- Unmask of a pending vector at cycle M -> wr_valid at M+1 if idle.
- cfg_we at cycle M is visible to arbitration at M+1.

## Test plan
- Program vec 3 = {0x0000_0001_FEE0_0030, 0x0000_0023}; pulse intr_req[3] at cycle 10 -> wr_valid at 12 with that addr/data, wr_id=3; wr_ready at 12 -> pend[3]=0 at 13.
- All 8 programmed, intr_req=0xFF in one cycle, wr_ready held 1 -> writes in order 0,1,…,7, one every 2 cycles; pend reaches 0 after the 8th.
- vec 5 masked, pulse intr_req[5] -> pend[5]=1, no write; deassert mask -> write with id 5 one cycle later (idle).
- vec 2 in ISSUE with wr_ready=0 for 5 cycles, pulse intr_req[2] twice -> coal_cnt=2, outputs stable; cfg_we rewrites entry 2 data to 0x99 -> current write keeps old data, next write uses 0x99.
- intr_req[1] on the cycle vec 1 is accepted -> pend[1] stays 1, second write for vec 1 follows; unprogrammed vec 6 requested -> pend[6]=1, never written.
- Assert rst_n=0 for one cycle during ISSUE -> next cycle wr_valid=0, pend=0, coal_cnt=0, table cleared.
